// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: memory geometry, the
// controller-stage client indices and the arbiter state encoding.
package mem_port_arbiter_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_WIDTH  = 8;
    localparam int MEM_DEPTH  = 1024;

    // Controller stages in descending fixed priority (0 = highest).
    localparam int LEARN_COST       = 0;
    localparam int STAGE_1          = 1;
    localparam int STAGE_2          = 2;
    localparam int STAGE_3          = 3;
    localparam int STAGE_4          = 4;
    localparam int STAGE_5          = 5;
    localparam int STAGE_6          = 6;
    localparam int SELECT_MY_ACTION = 7;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Rotated find-first-set: scans req_i starting at start_i, wrapping at N-1,
// and returns the first set position as a one-hot vector and an index.
module arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;

    // Duplicating the vector turns the wrap-around into a plain shift.
    assign req_dbl = {req_i, req_i};
    assign req_rot = N'(req_dbl >> start_i);

    // First set bit of the rotated vector, mapped back to a client index
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && req_rot[k]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'((int'(start_i) + k) % N);
            end
        end
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing one single-port memory among NUM_CLIENTS
// controller stages. Grants are registered and locked while the owner holds
// req; handoff to the next requester happens on the same edge the owner
// releases. Optional hold limit (MAX_HOLD > 0) evicts an owner that has kept
// the port for MAX_HOLD contended cycles; it must drop req before competing
// again. Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority with client 0 highest.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int NUM_CLIENTS = 8,
    parameter  int ADDR_WIDTH  = WORD_WIDTH,
    parameter  int DATA_WIDTH  = MEM_WIDTH,
    parameter  int MAX_HOLD    = 0,
    localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr_in,
    input  logic [NUM_CLIENTS-1:0]            we_in,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata_in,
    output logic [NUM_CLIENTS-1:0]            gnt,
    output logic [IDX_W-1:0]                  gnt_id,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [NUM_CLIENTS-1:0]            rvalid
);

    arb_state_e                 state_q, state_d;
    logic [NUM_CLIENTS-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]           gnt_id_q, gnt_id_d;
    logic [NUM_CLIENTS-1:0]     rvalid_q, rvalid_d;

    logic [NUM_CLIENTS-1:0]     blocked;
    logic [NUM_CLIENTS-1:0]     pick_req;
    logic [NUM_CLIENTS-1:0]     pick_onehot;
    logic [IDX_W-1:0]           pick_idx;
    logic [IDX_W-1:0]           pick_start;
    logic                       pick_found;
    logic                       contended;
    logic                       hold_hit;

    logic                       owner_req;
    logic                       owner_we;
    logic [ADDR_WIDTH-1:0]      owner_addr;
    logic [DATA_WIDTH-1:0]      owner_wdata;

    // Select the owner's lanes with the one-hot grant (all zero when idle)
    always_comb begin
        owner_req   = 1'b0;
        owner_we    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt_q[i]) begin
                owner_req   = req[i];
                owner_we    = we_in[i];
                owner_addr  = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                owner_wdata = wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mem_en    = owner_req;
    assign mem_we    = owner_req & owner_we;
    assign mem_addr  = owner_req ? owner_addr  : '0;
    assign mem_wdata = owner_req ? owner_wdata : '0;

    // Candidates: eligible requesters other than the current owner.
    assign pick_req  = req & ~blocked & ~gnt_q;
    assign contended = (state_q == OWN) && (|pick_req);

    arb_pick #(
        .N (NUM_CLIENTS)
    ) u_pick (
        .req_i    (pick_req),
        .start_i  (pick_start),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Move the search start just past each newly granted client
    always_comb begin
        ptr_d = ptr_q;
        if ((|gnt_d) && (gnt_d != gnt_q)) begin
            ptr_d = (gnt_id_d == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_id_d + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_start = ptr_q;
`else
    assign pick_start = '0;
`endif

    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int HOLD_W = $clog2(MAX_HOLD + 1);

            logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d, hold_inc;
            logic [NUM_CLIENTS-1:0] blocked_q, blocked_d;

            // Saturating increment; the limit is hit on the edge that completes it.
            assign hold_inc = (hold_cnt_q == HOLD_W'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + 1'b1;
            assign hold_hit = contended && (hold_inc == HOLD_W'(MAX_HOLD));
            assign blocked  = blocked_q;

            // Count contended cycles of one owner; evicted owners stay out until req drops
            always_comb begin
                hold_cnt_d = '0;
                if (contended && (gnt_d == gnt_q)) begin
                    hold_cnt_d = hold_inc;
                end
                blocked_d = (blocked_q | (hold_hit ? gnt_q : '0)) & req;
            end

            // Hold counter and eviction mask registers
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_cnt_q <= '0;
                    blocked_q  <= '0;
                end else begin
                    hold_cnt_q <= hold_cnt_d;
                    blocked_q  <= blocked_d;
                end
            end
        end else begin : g_no_hold
            assign hold_hit = 1'b0;
            assign blocked  = '0;
        end
    endgenerate

    // Grant FSM next state: acquire from idle, keep, hand off or release
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = OWN;
                    gnt_d    = pick_onehot;
                    gnt_id_d = pick_idx;
                end
            end
            OWN: begin
                if (!owner_req || hold_hit) begin
                    if (pick_found) begin
                        gnt_d    = pick_onehot;
                        gnt_id_d = pick_idx;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    // A read this cycle returns data next cycle to whoever owned it now.
    assign rvalid_d = (owner_req && !owner_we) ? gnt_q : '0;

    // Grant, owner index and read-valid registers
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (8 clients, MAX_HOLD = 4).
// Vector table for basic grant/read/handoff behaviour, hand-written
// sequences for arbitration order, hold eviction, write/read and reset.
// Expected rvalid values are queued per driven cycle and popped per edge.
module tb_mem_port_arbiter;

    localparam int NC = 8;
    localparam int AW = 16;
    localparam int DW = 8;

    logic             clk;
    logic             rst;
    logic [NC-1:0]    req;
    logic [NC*AW-1:0] addr_in;
    logic [NC-1:0]    we_in;
    logic [NC*DW-1:0] wdata_in;
    logic [NC-1:0]    gnt;
    logic [2:0]       gnt_id;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [NC-1:0]    rvalid;

    logic [AW-1:0]    lane_addr  [NC];
    logic [DW-1:0]    lane_wdata [NC];

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] sb[$];

    typedef struct {
        logic [7:0]  req;
        logic [7:0]  we;
        logic [7:0]  gnt;
        logic        en;
        logic        mwe;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rv_next;
    } vec_t;

    vec_t tbl[13];

    mem_port_arbiter #(
        .NUM_CLIENTS (NC),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_HOLD    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr_in   (addr_in),
        .we_in     (we_in),
        .wdata_in  (wdata_in),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rvalid    (rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        addr_in  = '0;
        wdata_in = '0;
        for (int i = 0; i < NC; i++) begin
            addr_in[i*AW +: AW]  = lane_addr[i];
            wdata_in[i*DW +: DW] = lane_wdata[i];
        end
    end

    function automatic logic [15:0] la(input int i);
        return 16'h0055 + 16'(i) * 16'h0080;
    endfunction

    function automatic logic [7:0] wd(input int i);
        return 8'hA0 + 8'(i);
    endfunction

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the rvalid expected after the edge.
    task automatic apply(input logic [7:0] r, input logic [7:0] w, input logic [7:0] rv_next);
        req   = r;
        we_in = w;
        sb.push_back(rv_next);
        #1;
    endtask

    // Advance one edge and compare rvalid against the queued expectation.
    task automatic tick();
        logic [7:0] exp_rv;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL sb_underflow: rvalid %0h with no queued expectation", rvalid);
        end else begin
            exp_rv = sb.pop_front();
            check("rvalid", rvalid, exp_rv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(8'h00, 8'h00, 8'h00);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int s;
        logic [7:0] fo;
        logic [7:0] so;
        int e[9];
        logic [7:0] oh;

        for (int i = 0; i < NC; i++) begin
            lane_addr[i]  = la(i);
            lane_wdata[i] = wd(i);
        end
        rst   = 1'b1;
        req   = '0;
        we_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check("rst_gnt", gnt, 8'h00);
        check("rst_gnt_id", gnt_id, 3'd0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_rvalid", rvalid, 8'h00);

        // Quiet bus for ten cycles
        for (int c = 0; c < 10; c++) begin
            apply(8'h00, 8'h00, 8'h00);
            check("idle_gnt", gnt, 8'h00);
            check("idle_mem_en", mem_en, 1'b0);
            tick();
        end

        // Vector table: single-client read/write, then a two-client handoff
`ifdef MEM_ARB_RR_EN
        f = 5;
        s = 1;
`else
        f = 1;
        s = 5;
`endif
        fo = 8'h01 << f;
        so = 8'h01 << s;
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[1]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[2]  = '{8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[3]  = '{8'h04, 8'h00, 8'h04, 1'b1, 1'b0, 16'h0155, 8'hA2, 8'h04};
        tbl[4]  = '{8'h04, 8'h04, 8'h04, 1'b1, 1'b1, 16'h0155, 8'hA2, 8'h00};
        tbl[5]  = '{8'h00, 8'h00, 8'h04, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[6]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[7]  = '{8'h22, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[8]  = '{8'h22, 8'h00, fo,    1'b1, 1'b0, la(f),    wd(f), fo};
        tbl[9]  = '{so,    8'h00, fo,    1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[10] = '{so,    8'h00, so,    1'b1, 1'b0, la(s),    wd(s), so};
        tbl[11] = '{8'h00, 8'h00, so,    1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        for (int r = 0; r < 13; r++) begin
            apply(tbl[r].req, tbl[r].we, tbl[r].rv_next);
            check($sformatf("vec%0d_gnt", r), gnt, tbl[r].gnt);
            if (|tbl[r].gnt) check($sformatf("vec%0d_gnt_id", r), gnt_id, oh2idx(tbl[r].gnt));
            check($sformatf("vec%0d_mem_en", r), mem_en, tbl[r].en);
            check($sformatf("vec%0d_mem_we", r), mem_we, tbl[r].mwe);
            check($sformatf("vec%0d_mem_addr", r), mem_addr, tbl[r].addr);
            check($sformatf("vec%0d_mem_wdata", r), mem_wdata, tbl[r].wdata);
            tick();
        end

        // Arbitration order: everyone requests, each owner drops one cycle after its grant
        do_reset();
        for (int j = 0; j < 9; j++) begin
`ifdef MEM_ARB_RR_EN
            e[j] = j % NC;
`else
            e[j] = j % 2;
`endif
        end
        apply(8'hFF, 8'hFF, 8'h00);
        check("order_pre_gnt", gnt, 8'h00);
        tick();
        for (int j = 0; j < 9; j++) begin
            oh = 8'h01 << e[j];
            apply(8'hFF, 8'hFF, 8'h00);
            check($sformatf("order%0d_gnt", j), gnt, oh);
            check($sformatf("order%0d_mem_en", j), mem_en, 1'b1);
            tick();
            apply(8'hFF & ~oh, 8'hFF, 8'h00);
            check($sformatf("order%0d_keep", j), gnt, oh);
            check($sformatf("order%0d_release_en", j), mem_en, 1'b0);
            tick();
        end
        apply(8'h00, 8'h00, 8'h00);
        tick();

        // Hold limit: client 3 owns, client 5 contends for four cycles
        do_reset();
        apply(8'h08, 8'hFF, 8'h00);
        tick();
        for (int k = 0; k < 5; k++) begin
            apply(8'h08, 8'hFF, 8'h00);
            check("hold_solo_gnt", gnt, 8'h08);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            apply(8'h28, 8'hFF, 8'h00);
            check($sformatf("hold_contend%0d_gnt", k), gnt, 8'h08);
            tick();
        end
        apply(8'h28, 8'hFF, 8'h00);
        check("hold_kick_gnt", gnt, 8'h20);
        tick();
        for (int k = 0; k < 5; k++) begin
            apply(8'h28, 8'hFF, 8'h00);
            check("hold_blocked_gnt", gnt, 8'h20);
            tick();
        end
        apply(8'h08, 8'hFF, 8'h00);
        check("hold_owner_drop_en", mem_en, 1'b0);
        tick();
        apply(8'h00, 8'h00, 8'h00);
        check("hold_evicted_not_regranted", gnt, 8'h00);
        tick();
        apply(8'h08, 8'hFF, 8'h00);
        tick();
        apply(8'h08, 8'hFF, 8'h00);
        check("hold_regrant_gnt", gnt, 8'h08);
        tick();
        apply(8'h00, 8'h00, 8'h00);
        tick();

        // Client 1 writes then reads the top address
        do_reset();
        lane_addr[1]  = 16'h03FF;
        lane_wdata[1] = 8'hA5;
        apply(8'h02, 8'h02, 8'h00);
        check("wr_pre_we", mem_we, 1'b0);
        tick();
        apply(8'h02, 8'h02, 8'h00);
        check("wr_gnt", gnt, 8'h02);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_addr", mem_addr, 16'h03FF);
        check("wr_mem_wdata", mem_wdata, 8'hA5);
        tick();
        apply(8'h02, 8'h00, 8'h02);
        check("rd_mem_en", mem_en, 1'b1);
        check("rd_mem_we", mem_we, 1'b0);
        check("rd_mem_addr", mem_addr, 16'h03FF);
        tick();
        apply(8'h00, 8'h00, 8'h00);
        check("rd_done_en", mem_en, 1'b0);
        check("rd_done_addr", mem_addr, 16'h0000);
        tick();
        lane_addr[1]  = la(1);
        lane_wdata[1] = wd(1);

        // Reset in the middle of client 6's read burst
        do_reset();
        apply(8'h40, 8'h00, 8'h00);
        tick();
        apply(8'h40, 8'h00, 8'h40);
        check("rstmid_gnt", gnt, 8'h40);
        tick();
        rst = 1'b1;
        apply(8'h40, 8'h00, 8'h00);
        check("rstmid_read_issued", mem_en, 1'b1);
        tick();
        check("rstmid_gnt_cleared", gnt, 8'h00);
        check("rstmid_gnt_id_cleared", gnt_id, 3'd0);
        check("rstmid_mem_en", mem_en, 1'b0);
        rst = 1'b0;
        apply(8'hFF, 8'hFF, 8'h00);
        check("rstmid_idle", gnt, 8'h00);
        tick();
        apply(8'hFF, 8'hFF, 8'h00);
        check("rstmid_ptr_zero", gnt, 8'h01);
        tick();
        apply(8'h00, 8'h00, 8'h00);
        tick();

        // A request that falls before the edge is never granted
        apply(8'h00, 8'h00, 8'h00);
        #2 req = 8'h80;
        #2 req = 8'h00;
        tick();
        apply(8'h00, 8'h00, 8'h00);
        check("glitch_no_grant", gnt, 8'h00);
        tick();

        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
